// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO for any depth, with occupancy level, almost-full/almost-empty
// thresholds, FWFT or registered read, synchronous flush and sticky error flags.
module sync_fifo_flags #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 8,
  parameter int FWFT          = 1,
  parameter int AFULL_THRESH  = 6,
  parameter int AEMPTY_THRESH = 1,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wfull,
  output logic                  walmost_full,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [LW-1:0]         level,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr_r;
  logic [AW-1:0]         rptr_r;
  logic [LW-1:0]         level_nxt_s;
  logic                  wincr_s;
  logic                  rincr_s;
  logic                  ovf_evt_s;
  logic                  unf_evt_s;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    if (ptr == AW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return ptr + AW'(1);
    end
  endfunction

  assign wincr_s = wen & ~wfull;
  assign rincr_s = ren & ~rempty;
  // A request dropped while the opposite side still moves data is not an error.
  assign ovf_evt_s = wen & wfull & ~ren & ~flush;
  assign unf_evt_s = ren & rempty & ~wen & ~flush;

  // Next occupancy; flags are registered from it so they track level exactly.
  always_comb begin
    level_nxt_s = level;
    if (flush) begin
      level_nxt_s = '0;
    end else if (wincr_s && !rincr_s) begin
      level_nxt_s = level + LW'(1);
    end else if (!wincr_s && rincr_s) begin
      level_nxt_s = level - LW'(1);
    end else begin
      level_nxt_s = level;
    end
  end

  // Pointers, level and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_r        <= '0;
      rptr_r        <= '0;
      level         <= '0;
      rempty        <= 1'b1;
      wfull         <= 1'b0;
      ralmost_empty <= 1'b1;
      walmost_full  <= (AFULL_THRESH == 0);
    end else begin
      if (flush) begin
        wptr_r <= '0;
        rptr_r <= '0;
      end else begin
        wptr_r <= wincr_s ? next_ptr(wptr_r) : wptr_r;
        rptr_r <= rincr_s ? next_ptr(rptr_r) : rptr_r;
      end
      level         <= level_nxt_s;
      rempty        <= (level_nxt_s == LW'(0));
      wfull         <= (level_nxt_s == LW'(DEPTH));
      ralmost_empty <= (level_nxt_s <= LW'(AEMPTY_THRESH));
      walmost_full  <= (level_nxt_s >= LW'(AFULL_THRESH));
    end
  end

  // Storage array, intentionally without reset.
  always_ff @(posedge clk) begin
    if (wincr_s && !flush) begin
      mem[wptr_r] <= wdata;
    end
  end

  // Sticky errors; a new event wins over a concurrent clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_evt_s ? 1'b1 : (err_clr ? 1'b0 : overflow);
      underflow <= unf_evt_s ? 1'b1 : (err_clr ? 1'b0 : underflow);
    end
  end

  if (FWFT != 0) begin : g_fwft
    always_comb begin
      rdata = mem[rptr_r];
    end
  end else begin : g_reg
    // Registered read port, holds its value between accepted reads.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rdata <= '0;
      end else if (rincr_s && !flush) begin
        rdata <= mem[rptr_r];
      end else begin
        rdata <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench: an FWFT instance and a registered-read instance share one stimulus
// stream; every expected value is written out by hand in the sequence below.
module tb_sync_fifo_flags;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       wen = 1'b0;
  logic       ren = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] wdata = 8'h00;

  logic       wfull1, wafull1, rempty1, raempty1, ovf1, unf1;
  logic [7:0] rdata1;
  logic [2:0] level1;
  logic       wfull0, wafull0, rempty0, raempty0, ovf0, unf0;
  logic [7:0] rdata0;
  logic [2:0] level0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(1), .AFULL_THRESH(4), .AEMPTY_THRESH(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .wen(wen), .wdata(wdata),
    .wfull(wfull1), .walmost_full(wafull1), .ren(ren), .rdata(rdata1),
    .rempty(rempty1), .ralmost_empty(raempty1), .level(level1),
    .err_clr(err_clr), .overflow(ovf1), .underflow(unf1));

  sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0), .AFULL_THRESH(4), .AEMPTY_THRESH(1)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .wen(wen), .wdata(wdata),
    .wfull(wfull0), .walmost_full(wafull0), .ren(ren), .rdata(rdata0),
    .rempty(rempty0), .ralmost_empty(raempty0), .level(level0),
    .err_clr(err_clr), .overflow(ovf0), .underflow(unf0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flags and level of both instances must agree with the hand-computed occupancy.
  task automatic chk_state(input string tag, input int lvl, input logic ovf, input logic unf);
    chk({tag, " level1"}, 32'(level1), 32'(lvl));
    chk({tag, " level0"}, 32'(level0), 32'(lvl));
    chk({tag, " rempty"}, {30'd0, rempty1, rempty0}, (lvl == 0) ? 32'd3 : 32'd0);
    chk({tag, " wfull"}, {30'd0, wfull1, wfull0}, (lvl == 5) ? 32'd3 : 32'd0);
    chk({tag, " aempty"}, {30'd0, raempty1, raempty0}, (lvl <= 1) ? 32'd3 : 32'd0);
    chk({tag, " afull"}, {30'd0, wafull1, wafull0}, (lvl >= 4) ? 32'd3 : 32'd0);
    chk({tag, " ovf"}, {30'd0, ovf1, ovf0}, ovf ? 32'd3 : 32'd0);
    chk({tag, " unf"}, {30'd0, unf1, unf0}, unf ? 32'd3 : 32'd0);
  endtask

  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic f, input logic c);
    wen = w; wdata = d; ren = r; flush = f; err_clr = c;
    @(posedge clk);
    #1;
    wen = 1'b0; ren = 1'b0; flush = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    // reset
    #12;
    chk_state("reset", 0, 1'b0, 1'b0);
    chk("reset rdata0", 32'(rdata0), 32'h00);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: fill then drain in order
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, 8'(8'h11 * i), 1'b0, 1'b0, 1'b0);
      chk_state($sformatf("fill%0d", i), i, 1'b0, 1'b0);
    end
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("drain%0d head1", i), 32'(rdata1), 32'(8'h11 * i));
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk($sformatf("drain%0d rdata0", i), 32'(rdata0), 32'(8'h11 * i));
      chk($sformatf("drain%0d level", i), 32'(level1), 32'(5 - i));
    end
    chk_state("drained", 0, 1'b0, 1'b0);

    // 2: wrap with level held at 2
    cyc(1'b1, 8'h60, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("wrap%0d head1", k), 32'(rdata1), 32'(8'h60 + k));
      cyc(1'b1, 8'(8'h62 + k), 1'b1, 1'b0, 1'b0);
      chk($sformatf("wrap%0d rdata0", k), 32'(rdata0), 32'(8'h60 + k));
      chk($sformatf("wrap%0d level", k), 32'(level1), 32'd2);
    end
    chk("wrap tail1 head", 32'(rdata1), 32'h74);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("wrap tail1 rdata0", 32'(rdata0), 32'h74);
    chk("wrap tail2 head", 32'(rdata1), 32'h75);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("wrap tail2 rdata0", 32'(rdata0), 32'h75);
    chk_state("wrap end", 0, 1'b0, 1'b0);

    // 3: simultaneous access at empty then at full
    cyc(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    chk_state("empty rw", 1, 1'b0, 1'b0);
    chk("empty rw head1", 32'(rdata1), 32'h3C);
    chk("empty rw rdata0 held", 32'(rdata0), 32'h75);
    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    chk_state("refill", 5, 1'b0, 1'b0);
    cyc(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    chk_state("full rw", 4, 1'b0, 1'b0);
    chk("full rw rdata0", 32'(rdata0), 32'h3C);
    chk("full rw head1", 32'(rdata1), 32'h41);

    // 4: overflow, underflow, clear, set-over-clear
    cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    chk_state("full again", 5, 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    chk_state("overflow", 5, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("intact%0d", i), 32'(rdata1), (i == 4) ? 32'h77 : 32'(8'h41 + i));
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("intact rdata0", 32'(rdata0), 32'h77);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk_state("underflow", 0, 1'b1, 1'b1);
    chk("underflow rdata0 held", 32'(rdata0), 32'h77);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk_state("err_clr", 0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk_state("set beats clr", 0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk_state("clr again", 0, 1'b0, 1'b0);

    // 5: flush mid-burst, then next write readable at the restarted head
    cyc(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    chk_state("pre flush", 3, 1'b0, 1'b0);
    cyc(1'b1, 8'hF0, 1'b0, 1'b1, 1'b0);
    chk_state("flush", 0, 1'b0, 1'b0);
    chk("flush rdata0 kept", 32'(rdata0), 32'h77);

    // 6: mode behaviour with 0xA5
    cyc(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk_state("post flush wr", 1, 1'b0, 1'b0);
    chk("fwft A5 before ren", 32'(rdata1), 32'hA5);
    chk("reg rdata before ren", 32'(rdata0), 32'h77);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("reg A5 after ren", 32'(rdata0), 32'hA5);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("reg A5 held", 32'(rdata0), 32'hA5);

    // 5b: asynchronous reset pulse in the middle of a cycle
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
    chk_state("pre reset", 2, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_state("async reset", 0, 1'b0, 1'b0);
    chk("async reset rdata0", 32'(rdata0), 32'h00);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    chk_state("post reset wr", 1, 1'b0, 1'b0);
    chk("post reset head1", 32'(rdata1), 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
